// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin 4:1 data mux with burst limit and registered valid/ready output slot
// One output register shared by four requesters; a winner is captured whenever the slot is free or draining.
module mux_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [3:0]       grant
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST - 1);

  logic [1:0]       last;
  logic [CW-1:0]    burst_cnt;
  logic             owned;
  logic             load;
  logic             cont;
  logic [1:0]       w;
  logic [WIDTH-1:0] w_data;

  assign load = (|req) & (~out_valid | out_ready) & ~reset;

  // owned is clear after reset, so the reset value of last (3) only seeds the
  // rotation and never earns requester 3 a continuation beat.
  assign cont = owned & req[last] & (burst_cnt < BURST_LIM);

  always_comb begin
    w = last;
    if (!cont) begin
      // scanned farthest-first so the nearest requester after last wins
      for (int i = 4; i >= 1; i--) begin
        if (req[last + 2'(i)]) w = last + 2'(i);
      end
    end
  end

  always_comb begin
    w_data = data_a;
    case (w)
      2'd0: w_data = data_a;
      2'd1: w_data = data_b;
      2'd2: w_data = data_c;
      2'd3: w_data = data_d;
      default: w_data = data_a;
    endcase
  end

  assign ack = load ? (4'b0001 << w) : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sel       <= 2'd0;
      grant     <= 4'b0000;
      last      <= 2'd3;
      burst_cnt <= '0;
      owned     <= 1'b0;
    end else if (load) begin
      out_data  <= w_data;
      out_valid <= 1'b1;
      sel       <= w;
      grant     <= 4'b0001 << w;
      last      <= w;
      owned     <= 1'b1;
      burst_cnt <= cont ? burst_cnt + 1'b1 : '0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      grant     <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed and random checks of mux_rr_arbiter (MAX_BURST 2 and 1) against a reference model
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] data_a, data_b, data_c, data_d;
  logic       out_ready;
  logic [3:0] ack0, ack1, out_data0, out_data1, grant0, grant1;
  logic       out_valid0, out_valid1;
  logic [1:0] sel0, sel1;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state, index 0: MAX_BURST=2, index 1: MAX_BURST=1
  int m_mb[2]    = '{2, 1};
  int m_last[2];
  int m_cnt[2];
  bit m_owned[2];
  bit m_valid[2];
  int m_data[2];
  int m_sel[2];
  int m_w[2];
  bit m_load[2];
  bit m_cont[2];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(4), .MAX_BURST(2)) dut0 (
    .clk(clk), .reset(reset), .req(req),
    .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
    .ack(ack0), .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .sel(sel0), .grant(grant0));

  mux_rr_arbiter #(.WIDTH(4), .MAX_BURST(1)) dut1 (
    .clk(clk), .reset(reset), .req(req),
    .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
    .ack(ack1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .sel(sel1), .grant(grant1));

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int din(input int i);
    case (i)
      0: return int'(data_a);
      1: return int'(data_b);
      2: return int'(data_c);
      default: return int'(data_d);
    endcase
  endfunction

  // Pick this cycle's winner from the rules: keep last while its burst allowance lasts,
  // otherwise the first requester found walking forward from last+1 around to last.
  task automatic model_decide(input int k);
    m_load[k] = !reset && (req != 0) && (!m_valid[k] || out_ready);
    m_cont[k] = m_owned[k] && req[m_last[k]] && (m_cnt[k] < m_mb[k] - 1);
    m_w[k] = m_last[k];
    if (!m_cont[k]) begin
      for (int j = 1; j <= 4; j++) begin
        if (req[(m_last[k] + j) % 4]) begin
          m_w[k] = (m_last[k] + j) % 4;
          break;
        end
      end
    end
  endtask

  task automatic model_clock(input int k);
    if (reset) begin
      m_valid[k] = 0; m_data[k] = 0; m_sel[k] = 0;
      m_last[k] = 3; m_cnt[k] = 0; m_owned[k] = 0;
    end else if (m_load[k]) begin
      m_cnt[k]   = m_cont[k] ? m_cnt[k] + 1 : 0;
      m_last[k]  = m_w[k];
      m_owned[k] = 1;
      m_valid[k] = 1;
      m_data[k]  = din(m_w[k]);
      m_sel[k]   = m_w[k];
    end else if (m_valid[k] && out_ready) begin
      m_valid[k] = 0;
    end
  endtask

  // Inputs are set at the falling edge before calling; ack is checked mid-low-phase,
  // registered outputs 1 time unit after the rising edge.
  task automatic cycle();
    #1;
    model_decide(0);
    model_decide(1);
    chk("ack_mb2", int'(ack0), m_load[0] ? (1 << m_w[0]) : 0);
    chk("ack_mb1", int'(ack1), m_load[1] ? (1 << m_w[1]) : 0);
    @(posedge clk);
    model_clock(0);
    model_clock(1);
    #1;
    chk("valid_mb2", int'(out_valid0), int'(m_valid[0]));
    chk("valid_mb1", int'(out_valid1), int'(m_valid[1]));
    chk("sel_mb2", int'(sel0), m_sel[0]);
    chk("sel_mb1", int'(sel1), m_sel[1]);
    chk("grant_mb2", int'(grant0), m_valid[0] ? (1 << m_sel[0]) : 0);
    chk("grant_mb1", int'(grant1), m_valid[1] ? (1 << m_sel[1]) : 0);
    if (m_valid[0] || reset) chk("data_mb2", int'(out_data0), m_data[0]);
    if (m_valid[1] || reset) chk("data_mb1", int'(out_data1), m_data[1]);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b0;
  endtask

  int rr_seq[9] = '{1, 1, 2, 2, 3, 3, 4, 4, 1};
  int alt_seq[4] = '{0, 3, 0, 3};

  initial begin
    reset = 1'b1; req = 4'hF; out_ready = 1'b1;
    data_a = 4'h1; data_b = 4'h2; data_c = 4'h3; data_d = 4'h4;
    @(negedge clk);

    // reset with every requester active
    do_reset(2);
    reset = 1'b1;
    #1;
    chk("reset_ack", int'(ack0), 0);
    chk("reset_valid", int'(out_valid0), 0);
    chk("reset_grant", int'(grant0), 0);
    chk("reset_sel", int'(sel0), 0);
    @(negedge clk);
    reset = 1'b0;

    // round robin with MAX_BURST=2: two beats each
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("rr_seq", int'(out_data0), rr_seq[i]);
    end

    // single requester c
    do_reset(1);
    req = 4'b0100; data_c = 4'hA;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("single_ack", int'(ack0), 4'b0100);
      #1;
      cycle();
      chk("single_data", int'(out_data0), 4'hA);
      chk("single_sel", int'(sel0), 2);
      chk("single_grant", int'(grant0), 4'b0100);
    end

    // backpressure: hold a beat of 5 then release
    req = 4'b0001; data_a = 4'h5;
    cycle();
    out_ready = 1'b0; req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ack", int'(ack0), 0);
      #1;
      cycle();
      chk("bp_data", int'(out_data0), 4'h5);
      chk("bp_valid", int'(out_valid0), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_load", int'(ack0 != 0), 1);
    #1;
    cycle();
    chk("bp_release_valid", int'(out_valid0), 1);

    // priority skip: last=1 then req 1001 -> 3 next, and MAX_BURST=1 alternates
    do_reset(1);
    req = 4'b0010;
    cycle();
    req = 4'b1001;
    cycle();
    chk("skip_first_mb2", int'(sel0), 3);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("alt_mb1", int'(sel1), alt_seq[i]);
    end

    // reset mid-burst, then first winner must be 0
    req = 4'hF;
    do_reset(1);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    chk("midreset_valid", int'(out_valid0), 0);
    reset = 1'b0;
    cycle();
    chk("after_reset_winner", int'(sel0), 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom_range(0, 15));
      data_a = 4'($urandom); data_b = 4'($urandom);
      data_c = 4'($urandom); data_d = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
